// File: rtl/mii_frame_scheduler.sv
// mii_frame_scheduler: round-robin sharing of one MII frame generator among N_REQ requesters
// Ports:
//   clk, i_rst_n            clock (rising edge), asynchronous active-low reset
//   i_enable                gates new grants; a frame in progress always finishes
//   i_req, i_req_interrupt  per-requester request level and scenario code byte
//   o_grant, o_done         one-hot grant held for the frame, one-cycle completion pulse
//   o_gen_start             one-cycle start pulse to the generator
//   o_gen_interrupt         scenario code latched at grant
//   i_gen_data, i_gen_ctrl  monitored generator output; ctrl != 0 marks a control byte
//   o_busy, o_timeout       not-idle flag, one-cycle abort pulse
//   o_frame_cnt             saturating count of completed frames
module mii_frame_scheduler #(
    parameter int         N_REQ          = 4,
    parameter int         IPG_CYCLES     = 12,
    parameter int         TIMEOUT_CYCLES = 256,
    parameter logic [7:0] START_CODE     = 8'hFB,
    parameter logic [7:0] TERMINATE_CODE = 8'hFD,
    parameter int         CNT_W          = 16
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_enable,
    input  logic [N_REQ-1:0]   i_req,
    input  logic [8*N_REQ-1:0] i_req_interrupt,
    output logic [N_REQ-1:0]   o_grant,
    output logic [N_REQ-1:0]   o_done,
    output logic               o_gen_start,
    output logic [7:0]         o_gen_interrupt,
    input  logic [7:0]         i_gen_data,
    input  logic [7:0]         i_gen_ctrl,
    output logic               o_busy,
    output logic               o_timeout,
    output logic [CNT_W-1:0]   o_frame_cnt
);
    localparam int PW = $clog2(N_REQ);
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int GW = $clog2(IPG_CYCLES + 1) + 1;

    typedef enum logic [1:0] {IDLE, WAIT_SOF, IN_FRAME, GAP} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    win_q, win_d, last_q, last_d, arb_idx, rot;
    logic [TW-1:0]    timer_q, timer_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [N_REQ-1:0] grant_q, grant_d, done_q, done_d;
    logic             start_q, start_d, busy_q, busy_d, timeout_q, timeout_d;
    logic [7:0]       intr_q, intr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             arb_go, sof, eof, tmo;

    assign arb_go = i_enable && (|i_req);
    assign sof    = (i_gen_ctrl != 8'h00) && (i_gen_data == START_CODE);
    assign eof    = (i_gen_ctrl != 8'h00) && (i_gen_data == TERMINATE_CODE);
    assign tmo    = timer_q == TW'(TIMEOUT_CYCLES - 1);

    // Scan from farthest to nearest after the last winner so the nearest requester wins.
    always_comb begin
        arb_idx = '0;
        rot     = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            rot = PW'((int'(last_q) + i) % N_REQ);
            if (i_req[rot]) arb_idx = rot;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            win_q     <= '0;
            last_q    <= PW'(N_REQ - 1);
            timer_q   <= '0;
            gap_q     <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            intr_q    <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            last_q    <= last_d;
            timer_q   <= timer_d;
            gap_q     <= gap_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            intr_q    <= intr_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     state_d = arb_go ? WAIT_SOF : IDLE;
            WAIT_SOF: state_d = sof ? IN_FRAME : (tmo ? GAP : WAIT_SOF);
            IN_FRAME: state_d = (eof || tmo) ? GAP : IN_FRAME;
            GAP:      state_d = (gap_q <= GW'(1)) ? IDLE : GAP;
        endcase
    end

    always_comb begin
        win_d     = win_q;
        last_d    = last_q;
        timer_d   = timer_q;
        gap_d     = gap_q;
        grant_d   = grant_q;
        done_d    = '0;
        start_d   = 1'b0;
        timeout_d = 1'b0;
        intr_d    = intr_q;
        cnt_d     = cnt_q;
        busy_d    = state_d != IDLE;
        case (state_q)
            IDLE: begin
                if (arb_go) begin
                    win_d   = arb_idx;
                    grant_d = N_REQ'(1) << arb_idx;
                    start_d = 1'b1;
                    intr_d  = i_req_interrupt[{arb_idx, 3'b000} +: 8];
                    timer_d = '0;
                end
            end
            WAIT_SOF, IN_FRAME: begin
                timer_d = timer_q + 1'b1;
                if (state_q == WAIT_SOF && sof) begin
                    timer_d = '0;
                end else if (state_q == IN_FRAME && eof) begin
                    done_d  = N_REQ'(1) << win_q;
                    cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                    grant_d = '0;
                    last_d  = win_q;
                    gap_d   = GW'(IPG_CYCLES);
                end else if (tmo) begin
                    // Abort still moves the pointer past the winner so it cannot starve others.
                    timeout_d = 1'b1;
                    grant_d   = '0;
                    last_d    = win_q;
                    gap_d     = GW'(IPG_CYCLES);
                end
            end
            GAP: gap_d = gap_q - 1'b1;
        endcase
    end

    assign o_grant         = grant_q;
    assign o_done          = done_q;
    assign o_gen_start     = start_q;
    assign o_gen_interrupt = intr_q;
    assign o_busy          = busy_q;
    assign o_timeout       = timeout_q;
    assign o_frame_cnt     = cnt_q;
endmodule

// File: tb/tb_mii_frame_scheduler.sv
// tb_mii_frame_scheduler: randomized frame-level check of mii_frame_scheduler against a reference model
module tb_mii_frame_scheduler;
    localparam int N   = 4;
    localparam int IPG = 12;
    localparam int TMO = 16;
    localparam int CW  = 3;

    logic          clk = 1'b0;
    logic          i_rst_n, i_enable;
    logic [N-1:0]  i_req, o_grant, o_done;
    logic [8*N-1:0] i_req_interrupt;
    logic          o_gen_start, o_busy, o_timeout;
    logic [7:0]    o_gen_interrupt, i_gen_data, i_gen_ctrl;
    logic [CW-1:0] o_frame_cnt;

    mii_frame_scheduler #(
        .N_REQ(N), .IPG_CYCLES(IPG), .TIMEOUT_CYCLES(TMO),
        .START_CODE(8'hFB), .TERMINATE_CODE(8'hFD), .CNT_W(CW)
    ) dut (
        .clk(clk), .i_rst_n(i_rst_n), .i_enable(i_enable), .i_req(i_req),
        .i_req_interrupt(i_req_interrupt), .o_grant(o_grant), .o_done(o_done),
        .o_gen_start(o_gen_start), .o_gen_interrupt(o_gen_interrupt),
        .i_gen_data(i_gen_data), .i_gen_ctrl(i_gen_ctrl), .o_busy(o_busy),
        .o_timeout(o_timeout), .o_frame_cnt(o_frame_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: last winner, completed frames, and the expected level outputs.
    int         last_w;
    int         frames;
    logic [3:0] exp_grant;
    logic       exp_busy;
    logic [7:0] exp_intr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] req, input int last);
        for (int i = 1; i <= N; i++)
            if (req[(last + i) % N]) return (last + i) % N;
        return -1;
    endfunction

    function automatic int sat_cnt(input int f);
        return (f > (1 << CW) - 1) ? (1 << CW) - 1 : f;
    endfunction

    task automatic tick(input logic xs, input logic [3:0] xd, input logic xt);
        @(posedge clk);
        @(negedge clk);
        check("start", 32'(o_gen_start), 32'(xs));
        check("done", 32'(o_done), 32'(xd));
        check("timeout", 32'(o_timeout), 32'(xt));
        check("grant", 32'(o_grant), 32'(exp_grant));
        check("busy", 32'(o_busy), 32'(exp_busy));
        check("intr", 32'(o_gen_interrupt), 32'(exp_intr));
        check("cnt", 32'(o_frame_cnt), 32'(sat_cnt(frames)));
    endtask

    task automatic noise(input logic [7:0] avoid);
        int pick;
        pick = $urandom_range(0, 3);
        i_gen_ctrl = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
        i_gen_data = (pick == 0) ? 8'hFB : (pick == 1) ? 8'hFD : 8'($urandom);
        if (i_gen_ctrl != 8'h00 && i_gen_data == avoid) i_gen_data = ~avoid;
        i_req           = 4'($urandom);
        i_enable        = 1'($urandom);
        i_req_interrupt = $urandom;
    endtask

    task automatic gap_run();
        for (int j = 1; j <= IPG; j++) begin
            noise(8'hFB);
            exp_busy = (j < IPG);
            tick(1'b0, 4'b0, 1'b0);
        end
    endtask

    // One complete grant: start pulse, SOF after sof_k cycles, EOF after body_m cycles,
    // either of which past the timeout window yields an abort; then the inter-packet gap.
    task automatic frame(input logic [3:0] req, input logic [31:0] intr, input int sof_k, input int body_m);
        int w;
        bit hit;
        w               = rr_pick(req, last_w);
        i_req           = req;
        i_enable        = 1'b1;
        i_req_interrupt = intr;
        i_gen_ctrl      = 8'h00;
        i_gen_data      = 8'h00;
        exp_grant       = 4'b1 << w;
        exp_busy        = 1'b1;
        exp_intr        = intr[8*w +: 8];
        tick(1'b1, 4'b0, 1'b0);
        hit = 1'b0;
        for (int k = 0; k < TMO && !hit; k++) begin
            noise(8'hFB);
            if (k == sof_k) begin
                i_gen_ctrl = 8'($urandom) | 8'h01;
                i_gen_data = 8'hFB;
                hit        = 1'b1;
            end
            if (k == TMO - 1 && !hit) begin
                exp_grant = 4'b0;
                last_w    = w;
                tick(1'b0, 4'b0, 1'b1);
            end else begin
                tick(1'b0, 4'b0, 1'b0);
            end
        end
        if (!hit) begin
            gap_run();
            return;
        end
        hit = 1'b0;
        for (int m = 0; m < TMO && !hit; m++) begin
            noise(8'hFD);
            if (m == body_m) begin
                i_gen_ctrl = 8'($urandom) | 8'h01;
                i_gen_data = 8'hFD;
                hit        = 1'b1;
                exp_grant  = 4'b0;
                last_w     = w;
                frames++;
                tick(1'b0, 4'b1 << w, 1'b0);
            end else if (m == TMO - 1) begin
                exp_grant = 4'b0;
                last_w    = w;
                tick(1'b0, 4'b0, 1'b1);
            end else begin
                tick(1'b0, 4'b0, 1'b0);
            end
        end
        gap_run();
    endtask

    task automatic idle_cycles(input int n, input logic en, input logic [3:0] req);
        for (int j = 0; j < n; j++) begin
            i_enable   = en;
            i_req      = req;
            i_gen_ctrl = 8'h00;
            tick(1'b0, 4'b0, 1'b0);
        end
    endtask

    // Asynchronous reset: outputs must clear before the next clock edge.
    task automatic do_reset();
        #2 i_rst_n = 1'b0;
        #1;
        check("rst_grant", 32'(o_grant), 32'h0);
        check("rst_done", 32'(o_done), 32'h0);
        check("rst_start", 32'(o_gen_start), 32'h0);
        check("rst_intr", 32'(o_gen_interrupt), 32'h0);
        check("rst_busy", 32'(o_busy), 32'h0);
        check("rst_timeout", 32'(o_timeout), 32'h0);
        check("rst_cnt", 32'(o_frame_cnt), 32'h0);
        last_w     = N - 1;
        frames     = 0;
        exp_grant  = 4'b0;
        exp_busy   = 1'b0;
        exp_intr   = 8'h00;
        i_req      = 4'b0;
        i_gen_ctrl = 8'h00;
        @(negedge clk);
        i_rst_n = 1'b1;
    endtask

    initial begin
        i_rst_n         = 1'b1;
        i_enable        = 1'b0;
        i_req           = 4'b0;
        i_req_interrupt = '0;
        i_gen_data      = 8'h00;
        i_gen_ctrl      = 8'h00;
        @(negedge clk);
        do_reset();
        idle_cycles(3, 1'b1, 4'b0);
        frame(4'b0001, 32'h0, 2, 5);
        do_reset();
        for (int f = 0; f < 4; f++) frame(4'b1111, 32'hA3A2A1A0, 1, 3);
        frame(4'b0101, 32'h55667788, 99, 0);
        frame(4'b0101, 32'h11223344, 15, 15);
        idle_cycles(50, 1'b0, 4'b0010);
        frame(4'b0010, 32'hDEADBEEF, 0, 20);
        frame(4'b0010, 32'h0BADF00D, 3, 4);
        i_req = 4'b0100;
        i_enable = 1'b1;
        last_w = rr_pick(4'b0100, last_w);
        exp_grant = 4'b0100;
        exp_busy = 1'b1;
        exp_intr = 8'h77;
        i_req_interrupt = 32'h00770000;
        tick(1'b1, 4'b0, 1'b0);
        i_gen_ctrl = 8'h01;
        i_gen_data = 8'hFB;
        tick(1'b0, 4'b0, 1'b0);
        i_gen_ctrl = 8'h00;
        tick(1'b0, 4'b0, 1'b0);
        do_reset();
        frame(4'b1000, 32'hC0C1C2C3, 0, 0);
        for (int r = 0; r < 30; r++) begin
            idle_cycles($urandom_range(0, 3), 1'b0, 4'($urandom));
            frame(4'($urandom_range(1, 15)), $urandom,
                  ($urandom_range(0, 5) == 0) ? 20 : $urandom_range(0, TMO - 1),
                  ($urandom_range(0, 5) == 0) ? 20 : $urandom_range(0, TMO - 1));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mii_frame_scheduler.md
Name: mii_frame_scheduler

Overview:
Shares one MII Ethernet frame generator among N_REQ requesters using round-robin arbitration. For each grant it issues a single-cycle start pulse and forwards the winner's interrupt/scenario code. It then tracks the generator's data/ctrl output for the start and terminate control codes, and enforces an inter-packet gap before the next grant. It sits directly in front of the frame generator, and its outputs drive that generator's start and interrupt inputs.

Parameters:
N_REQ, 4, number of requesters (2..8)
IPG_CYCLES, 12, idle cycles enforced after each frame end or abort (>=1)
TIMEOUT_CYCLES, 256, maximum cycles allowed in WAIT_SOF or in IN_FRAME before abort
START_CODE, 8'hFB, control byte marking start of frame
TERMINATE_CODE, 8'hFD, control byte marking end of frame
CNT_W, 16, width of the completed-frame counter

Ports:
clk  in  1  clock; all logic on the rising edge
i_rst_n  in  1  asynchronous reset, active-low
i_enable  in  1  when 0, no new grants are issued; a frame in progress still completes
i_req  in  N_REQ  per-requester frame request (level)
i_req_interrupt  in  8*N_REQ  per-requester scenario code; byte k belongs to requester k
o_grant  out  N_REQ  one-hot grant; held from start until frame end or abort
o_done  out  N_REQ  one-cycle pulse to the granted requester on frame completion
o_gen_start  out  1  one-cycle start pulse to the generator
o_gen_interrupt  out  8  scenario code latched at grant
i_gen_data  in  8  generator transmit data (monitored)
i_gen_ctrl  in  8  generator transmit control (monitored; nonzero means a control byte)
o_busy  out  1  1 in any state other than IDLE
o_timeout  out  1  one-cycle pulse on abort
o_frame_cnt  out  CNT_W  count of completed frames, saturating

Behaviour:
- All outputs are registered.
- Reset values: o_grant=0, o_done=0, o_gen_start=0, o_gen_interrupt=0, o_busy=0, o_timeout=0, o_frame_cnt=0. State resets to IDLE and the round-robin pointer resets so that requester 0 has highest priority.
- Reset asserted mid-frame returns the block to IDLE immediately, with no done pulse and no timeout pulse.
- States: IDLE, WAIT_SOF, IN_FRAME, GAP.
- A control byte is detected when i_gen_ctrl!=0. Control bytes other than the code being waited for are ignored.
- IDLE:
  - Arbitration runs only when i_enable=1 and |i_req=1.
  - Priority search starts at (last winner + 1) mod N_REQ.
  - On the next edge: o_grant=onehot(winner), o_gen_start=1 for exactly one cycle, o_gen_interrupt=i_req_interrupt[winner], timer cleared, state goes to WAIT_SOF.
  - Latency from request seen in IDLE to o_gen_start is 1 cycle.
- WAIT_SOF:
  - On a control byte equal to START_CODE: go to IN_FRAME and clear the timer.
  - Otherwise the timer increments. When timer==TIMEOUT_CYCLES-1, abort.
- IN_FRAME:
  - On a control byte equal to TERMINATE_CODE, on the next edge: o_done[winner]=1 for one cycle, o_frame_cnt increments (holding at all-ones), o_grant clears, the round-robin pointer updates to the winner, the gap counter loads IPG_CYCLES, and state goes to GAP.
  - START_CODE seen in IN_FRAME is ignored.
  - The timeout rule is the same as in WAIT_SOF.
- Abort, from either WAIT_SOF or IN_FRAME: o_timeout=1 for one cycle, o_grant clears, no o_done, no counter change, the pointer still advances past the winner, and state goes to GAP with IPG_CYCLES loaded.
- GAP: the counter decrements each cycle. On reaching 0 the state goes to IDLE. No grants are issued during GAP.
- Minimum spacing from frame end to the next o_gen_start is IPG_CYCLES+2 cycles.
- A requester deasserting i_req after grant has no effect; the frame finishes normally.
- i_req_interrupt changes after grant do not affect o_gen_interrupt.
- i_enable falling mid-frame has no effect until the block returns to IDLE.
- Counter saturation: at all-ones, further completions leave o_frame_cnt unchanged; o_done still pulses.

Test Plan:
1. Single frame, defaults: i_req=4'b0001, interrupt byte0=8'h00, and the model generator emits FB ... FD. Required: o_gen_start one cycle after the request, o_grant=0001 held until FD, o_done[0] pulses one cycle after FD, o_frame_cnt=1, next grant no earlier than 14 cycles after FD.
2. Round-robin: i_req=4'b1111 held for 4 frames. Required: grant order 0,1,2,3; o_gen_interrupt matches each requester's byte (e.g. 8'hA0..8'hA3); o_frame_cnt=4.
3. Timeout in WAIT_SOF, TIMEOUT_CYCLES=16: the generator never emits FB. Required: o_timeout pulses 16 cycles after o_gen_start, no o_done, o_frame_cnt unchanged, then a 12-cycle GAP followed by a grant to the next requester.
4. i_enable=0 with i_req=4'b0010: no o_gen_start for 50 cycles. Raising i_enable gives o_gen_start one cycle later with o_grant=0010. Dropping i_enable mid-frame still produces o_done[1].
5. Reset mid-frame: i_rst_n low during IN_FRAME. Required: all outputs 0 asynchronously; after release, i_req=4'b1000 gets a grant in 1 cycle; o_frame_cnt=0.
6. Saturation with CNT_W=2: 5 completed frames. Required: o_frame_cnt=3 and 5 o_done pulses.
